// File: rtl/multdiv_sequencer.sv
// Launches mul/div from DX into the iterative multdiv unit, tracks the
// in-flight instruction and arbitrates its result onto the writeback port.
module multdiv_sequencer #(
    parameter int TIMEOUT      = 64,
    parameter int RSTATUS_REG  = 30,
    parameter int MUL_EXC_CODE = 4,
    parameter int DIV_EXC_CODE = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_insn,
    input  logic        dx_fire,
    input  logic [31:0] data_result,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    input  logic        wb_ack,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        multOngoing,
    output logic [31:0] inM,
    output logic        wb_req,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        md_timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]  state;
    logic [6:0]  cnt;
    logic [4:0]  rd_q;
    logic [31:0] data_q;
    logic        is_md;
    logic        launch;

    assign is_md  = (dx_insn[31:27] == 5'd0) && (dx_insn[6:3] == 4'b0011);
    assign launch = is_md && dx_fire && (state == S_IDLE) && !reset;

    // Combinational so the multdiv unit samples DX operands on this edge.
    assign ctrl_MULT = launch && !dx_insn[2];
    assign ctrl_DIV  = launch && dx_insn[2];

    assign multOngoing = (state != S_IDLE);
    assign wb_req      = (state == S_WB);
    assign wb_rd       = (state == S_WB) ? rd_q : 5'd0;
    assign wb_data     = (state == S_WB) ? data_q : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 7'd0;
            inM        <= 32'd0;
            rd_q       <= 5'd0;
            data_q     <= 32'd0;
            md_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state <= S_RUN;
                        inM   <= dx_insn;
                        cnt   <= 7'd0;
                    end
                end
                S_RUN: begin
                    if (data_resultRDY) begin
                        // Exception write wins over rd==0 suppression.
                        if (data_exception) begin
                            state  <= S_WB;
                            rd_q   <= 5'(RSTATUS_REG);
                            data_q <= inM[2] ? 32'(DIV_EXC_CODE)
                                             : 32'(MUL_EXC_CODE);
                        end else if (inM[26:22] != 5'd0) begin
                            state  <= S_WB;
                            rd_q   <= inM[26:22];
                            data_q <= data_result;
                        end else begin
                            state <= S_IDLE;
                            inM   <= 32'd0;
                        end
                    end else if (cnt == 7'(TIMEOUT - 1)) begin
                        md_timeout <= 1'b1;
                        state      <= S_IDLE;
                        inM        <= 32'd0;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                S_WB: begin
                    if (wb_ack) begin
                        state  <= S_IDLE;
                        inM    <= 32'd0;
                        rd_q   <= 5'd0;
                        data_q <= 32'd0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    inM   <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench for multdiv_sequencer against an
// outcome model derived from the launch/result/writeback rules.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dx_insn = '0;
    logic        dx_fire = 1'b0;
    logic [31:0] data_result = '0;
    logic        data_resultRDY = 1'b0;
    logic        data_exception = 1'b0;
    logic        wb_ack = 1'b0;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        multOngoing;
    logic [31:0] inM;
    logic        wb_req;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        md_timeout;

    int total = 0;
    int bad   = 0;

    multdiv_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .dx_insn        (dx_insn),
        .dx_fire        (dx_fire),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .wb_ack         (wb_ack),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .multOngoing    (multOngoing),
        .inM            (inM),
        .wb_req         (wb_req),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .md_timeout     (md_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(input bit div, input logic [4:0] rd);
        logic [4:0] rs;
        logic [4:0] rt;
        rs = 5'($urandom);
        rt = 5'($urandom);
        return {5'd0, rd, rs, rt, 5'd0, 4'b0011, div, 2'b00};
    endfunction

    // One full mul/div transaction; expected outcome follows the rules:
    // exception -> r30 gets 4/5, else rd!=0 -> rd gets result, else no write.
    task automatic do_op(input bit div, input logic [4:0] rd,
                         input logic [31:0] res, input bit exc,
                         input int lat, input int ackdly);
        logic [31:0] insn;
        bit          wr;
        logic [4:0]  erd;
        logic [31:0] edata;
        insn = mk(div, rd);
        wr    = exc || (rd != 5'd0);
        erd   = exc ? 5'd30 : rd;
        edata = exc ? (div ? 32'd5 : 32'd4) : res;
        dx_insn = insn;
        dx_fire = 1'b1;
        #1;
        total++;
        if (ctrl_MULT !== !div || ctrl_DIV !== div) begin
            bad++;
            $display("FAIL launch_ctrl mult=%b div=%b want_div=%b",
                     ctrl_MULT, ctrl_DIV, div);
        end
        tick();
        dx_fire = 1'b0;
        dx_insn = '0;
        #1;
        total++;
        if (multOngoing !== 1'b1 || inM !== insn || ctrl_MULT || ctrl_DIV) begin
            bad++;
            $display("FAIL run_entry ongoing=%b inM=%h want %h", multOngoing, inM, insn);
        end
        for (int i = 1; i < lat; i++) tick();
        total++;
        if (multOngoing !== 1'b1 || wb_req !== 1'b0 || inM !== insn) begin
            bad++;
            $display("FAIL run_hold ongoing=%b wb_req=%b inM=%h", multOngoing, wb_req, inM);
        end
        data_resultRDY = 1'b1;
        data_result    = res;
        data_exception = exc;
        tick();
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        data_result    = '0;
        if (wr) begin
            for (int k = 0; k <= ackdly; k++) begin
                total++;
                if (wb_req !== 1'b1 || wb_rd !== erd || wb_data !== edata ||
                    multOngoing !== 1'b1 || inM !== insn) begin
                    bad++;
                    $display("FAIL wb_out req=%b rd=%0d data=%h want rd=%0d data=%h",
                             wb_req, wb_rd, wb_data, erd, edata);
                end
                if (k < ackdly) tick();
            end
            wb_ack = 1'b1;
            tick();
            wb_ack = 1'b0;
        end
        total++;
        if (multOngoing !== 1'b0 || wb_req !== 1'b0 || inM !== 32'd0 ||
            wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            bad++;
            $display("FAIL done ongoing=%b wb_req=%b inM=%h want idle",
                     multOngoing, wb_req, inM);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        dx_insn = mk(1'b0, 5'd7);
        dx_fire = 1'b1;
        #1;
        total++;
        if (ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl mult=%b div=%b want 0", ctrl_MULT, ctrl_DIV);
        end
        tick();
        tick();
        total++;
        if (multOngoing !== 1'b0 || wb_req !== 1'b0 || inM !== 32'd0 ||
            md_timeout !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_state ongoing=%b wb_req=%b inM=%h to=%b",
                     multOngoing, wb_req, inM, md_timeout);
        end
        dx_fire = 1'b0;
        dx_insn = '0;
        reset   = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_op(1'b0, 5'd3, 32'h0000_0042, 1'b0, 17, 2);
    endtask

    task automatic test_exception();
        do_op(1'b1, 5'($urandom), $urandom, 1'b1, 5, 1);
        do_op(1'b0, 5'($urandom), $urandom, 1'b1, 9, 0);
        do_op(1'b0, 5'd0, $urandom, 1'b1, 3, 0);
    endtask

    task automatic test_rd_zero();
        do_op(1'b0, 5'd0, 32'hdead_beef, 1'b0, 6, 0);
        do_op(1'b1, 5'd0, $urandom, 1'b0, 1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            do_op(1'($urandom), 5'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0),
                  $urandom_range(1, 40), $urandom_range(0, 4));
        end
    endtask

    task automatic test_ignore();
        logic [31:0] i1;
        logic [31:0] i2;
        i1 = mk(1'b0, 5'd5);
        i2 = mk(1'b1, 5'd9);
        dx_insn = i1;
        dx_fire = 1'b1;
        tick();
        dx_insn = i2;
        #1;
        total++;
        if (ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
            bad++;
            $display("FAIL ignore_run_ctrl mult=%b div=%b want 0", ctrl_MULT, ctrl_DIV);
        end
        tick();
        tick();
        total++;
        if (inM !== i1 || multOngoing !== 1'b1) begin
            bad++;
            $display("FAIL ignore_run_inM inM=%h want %h", inM, i1);
        end
        dx_fire = 1'b0;
        data_resultRDY = 1'b1;
        data_result    = 32'h1234_5678;
        tick();
        data_resultRDY = 1'b0;
        dx_fire = 1'b1;
        #1;
        total++;
        if (ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0 || wb_rd !== 5'd5 ||
            wb_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL ignore_wb mult=%b div=%b rd=%0d data=%h",
                     ctrl_MULT, ctrl_DIV, wb_rd, wb_data);
        end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        #1;
        total++;
        if (ctrl_DIV !== 1'b1 || ctrl_MULT !== 1'b0 || multOngoing !== 1'b0) begin
            bad++;
            $display("FAIL relaunch_ctrl div=%b mult=%b ongoing=%b want 1/0/0",
                     ctrl_DIV, ctrl_MULT, multOngoing);
        end
        tick();
        dx_fire = 1'b0;
        dx_insn = '0;
        total++;
        if (inM !== i2 || multOngoing !== 1'b1) begin
            bad++;
            $display("FAIL relaunch_inM inM=%h want %h", inM, i2);
        end
        data_resultRDY = 1'b1;
        data_result    = 32'h0000_0007;
        tick();
        data_resultRDY = 1'b0;
        total++;
        if (wb_req !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'd7) begin
            bad++;
            $display("FAIL relaunch_wb req=%b rd=%0d data=%h want 1/9/7",
                     wb_req, wb_rd, wb_data);
        end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        data_resultRDY = 1'b1;
        data_result    = 32'hffff_ffff;
        tick();
        data_resultRDY = 1'b0;
        total++;
        if (wb_req !== 1'b0 || multOngoing !== 1'b0) begin
            bad++;
            $display("FAIL idle_rdy req=%b ongoing=%b want 0", wb_req, multOngoing);
        end
    endtask

    task automatic test_timeout();
        dx_insn = mk(1'b1, 5'd12);
        dx_fire = 1'b1;
        tick();
        dx_fire = 1'b0;
        dx_insn = '0;
        for (int c = 1; c < 64; c++) tick();
        total++;
        if (multOngoing !== 1'b1 || md_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early ongoing=%b to=%b want 1/0", multOngoing, md_timeout);
        end
        tick();
        total++;
        if (multOngoing !== 1'b0 || md_timeout !== 1'b1 || wb_req !== 1'b0 ||
            inM !== 32'd0) begin
            bad++;
            $display("FAIL timeout_exit ongoing=%b to=%b req=%b inM=%h",
                     multOngoing, md_timeout, wb_req, inM);
        end
        do_op(1'b0, 5'd17, $urandom, 1'b0, 4, 1);
        total++;
        if (md_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky to=%b want 1", md_timeout);
        end
    endtask

    task automatic test_reset_wb();
        dx_insn = mk(1'b0, 5'd21);
        dx_fire = 1'b1;
        tick();
        dx_fire = 1'b0;
        dx_insn = '0;
        tick();
        data_resultRDY = 1'b1;
        data_result    = 32'hcafe_f00d;
        tick();
        data_resultRDY = 1'b0;
        total++;
        if (wb_req !== 1'b1 || wb_rd !== 5'd21) begin
            bad++;
            $display("FAIL prereset_wb req=%b rd=%0d want 1/21", wb_req, wb_rd);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (wb_req !== 1'b0 || multOngoing !== 1'b0 || inM !== 32'd0 ||
            md_timeout !== 1'b0 || wb_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_wb req=%b ongoing=%b inM=%h to=%b",
                     wb_req, multOngoing, inM, md_timeout);
        end
        data_resultRDY = 1'b1;
        data_result    = 32'h1111_2222;
        tick();
        data_resultRDY = 1'b0;
        tick();
        total++;
        if (wb_req !== 1'b0 || multOngoing !== 1'b0) begin
            bad++;
            $display("FAIL late_rdy req=%b ongoing=%b want 0", wb_req, multOngoing);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exception();
        test_rd_zero();
        test_ignore();
        test_random();
        test_timeout();
        test_reset_wb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
